// File: rtl/aes_stress_pkg.sv
// Shared types and constants for the AES stress harness.
//   block_t    : 128-bit data block (plaintext, key, ciphertext, signature)
//   state_e    : harness FSM states
//   LfsrTaps   : Galois feedback mask for x^128 + x^7 + x^2 + x + 1
//   lfsr_next(): one Galois LFSR step
package aes_stress_pkg;

  typedef logic [127:0] block_t;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StDone,
    StErr
  } state_e;

  localparam block_t LfsrTaps = 128'h87;

  // Shift left; the bit falling out of position 127 folds back through the taps.
  function automatic block_t lfsr_next(input block_t s);
    return {s[126:0], 1'b0} ^ (s[127] ? LfsrTaps : '0);
  endfunction

endpackage

// File: rtl/AES128_encrypt.sv
// Iterative AES-128 encryption core, one round per clock.
//   clk, rst : clock and synchronous active-high reset
//   start    : 1-cycle pulse; in/key are sampled on this cycle (restarts any block in flight)
//   in, key  : plaintext and cipher key
//   out      : ciphertext, held until the next completion
//   finish   : 1-cycle pulse coincident with a new ciphertext on out
// Latency: finish is high in the 11th cycle after the start edge.
module AES128_encrypt (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] in,
  input  logic [127:0] key,
  output logic [127:0] out,
  output logic         finish
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254, which maps 0 to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = x;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, tmp;
    {w0, w1, w2, w3} = k;
    tmp = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = w0 ^ tmp;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // SubBytes + ShiftRows (+ MixColumns unless last). Byte n sits at row n%4, column n/4.
  function automatic logic [127:0] round_fn(input logic [127:0] s, input logic last);
    logic [127:0] t;
    logic [127:0] m;
    logic [31:0]  col;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        t[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
      end
    end
    m = t;
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        col = t[127-32*c -: 32];
        {a0, a1, a2, a3} = col;
        m[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                             xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
      end
    end
    return m;
  endfunction

  logic [127:0] st_q, rk_q, out_q;
  logic [127:0] rk_nxt, st_nxt;
  logic [7:0]   rc_q;
  logic [3:0]   rnd_q;
  logic         run_q, finish_q;

  always_comb begin
    rk_nxt = next_key(rk_q, rc_q);
    st_nxt = round_fn(st_q, rnd_q == 4'd10) ^ rk_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= '0;
      rk_q     <= '0;
      out_q    <= '0;
      rc_q     <= 8'h01;
      rnd_q    <= 4'd1;
      run_q    <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      finish_q <= 1'b0;
      if (start) begin
        st_q  <= in ^ key;
        rk_q  <= key;
        rc_q  <= 8'h01;
        rnd_q <= 4'd1;
        run_q <= 1'b1;
      end else if (run_q) begin
        st_q  <= st_nxt;
        rk_q  <= rk_nxt;
        rc_q  <= xtime(rc_q);
        rnd_q <= rnd_q + 4'd1;
        if (rnd_q == 4'd10) begin
          run_q    <= 1'b0;
          out_q    <= st_nxt;
          finish_q <= 1'b1;
        end
      end
    end
  end

  assign out    = out_q;
  assign finish = finish_q;

endmodule

// File: rtl/lfsr128_src.sv
// 128-bit Galois LFSR block source.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset, reloads the seed
//   step_i : advance one step on this edge
//   out_o  : current LFSR value
// A zero SEED would lock the register at zero, so it is replaced by 1.
module lfsr128_src
  import aes_stress_pkg::*;
#(
  parameter block_t SEED = 128'h1
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   step_i,
  output block_t out_o
);

  localparam block_t SeedEff = (SEED == '0) ? block_t'(1) : SEED;

  block_t lfsr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= SeedEff;
    end else if (step_i) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign out_o = lfsr_q;

endmodule

// File: rtl/aes_stress_harness.sv
// Self-running stress harness around AES128_encrypt.
//   clk_i, rst_i   : clock; synchronous active-high reset (also resets the core)
//   go_i           : start pulse, honoured in IDLE, DONE or ERR
//   iterations_i   : block target sampled on go (0 = free-run)
//   out_o          : last captured ciphertext
//   signature_o    : MISR fold rotl(sig,1) ^ ct over all ciphertexts since go
//   count_o        : completed blocks since go (wraps)
//   busy_o/done_o/timeout_err_o : ISSUE|WAIT / DONE / ERR
// Optional AES_STRESS_GOLDEN_CHECK_EN adds expected_sig_i (sampled on go) and
// pass_o (final signature matches on entering DONE; 0 otherwise).
module aes_stress_harness
  import aes_stress_pkg::*;
#(
  parameter block_t      IN_SEED        = 128'h00112233445566778899aabbccddeeff,
  parameter block_t      KEY_SEED       = 128'h000102030405060708090a0b0c0d0e0f,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             go_i,
  input  logic [CNT_W-1:0] iterations_i,
  output block_t           out_o,
  output block_t           signature_o,
  output logic [CNT_W-1:0] count_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             timeout_err_o
`ifdef AES_STRESS_GOLDEN_CHECK_EN
  ,
  input  block_t           expected_sig_i,
  output logic             pass_o
`endif
);

  localparam int unsigned WdW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] count_q, count_d, count_inc;
  block_t           sig_q, sig_d, out_q, out_d, sig_fold;
  logic [WdW-1:0]   wd_q, wd_d;

  logic   core_start, core_finish;
  block_t core_ct, pt_blk, key_blk;
  logic   go_accept, enter_done;

  // Both sources step on the ISSUE edge, the same edge on which the core samples them.
  lfsr128_src #(.SEED(IN_SEED)) u_pt_src (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .step_i (core_start),
    .out_o  (pt_blk)
  );

  lfsr128_src #(.SEED(KEY_SEED)) u_key_src (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .step_i (core_start),
    .out_o  (key_blk)
  );

  AES128_encrypt u_core (
    .clk    (clk_i),
    .rst    (rst_i),
    .start  (core_start),
    .in     (pt_blk),
    .key    (key_blk),
    .out    (core_ct),
    .finish (core_finish)
  );

  assign core_start = (state_q == StIssue);
  assign count_inc  = count_q + CNT_W'(1);
  assign sig_fold   = {sig_q[126:0], sig_q[127]} ^ core_ct;

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    count_d    = count_q;
    sig_d      = sig_q;
    out_d      = out_q;
    wd_d       = wd_q;
    go_accept  = 1'b0;
    enter_done = 1'b0;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (go_i) begin
          go_accept = 1'b1;
          state_d   = StIssue;
          target_d  = iterations_i;
          count_d   = '0;
          sig_d     = '0;
          out_d     = '0;
        end
      end
      StIssue: begin
        wd_d    = '0;
        state_d = StWait;
      end
      StWait: begin
        // A finish on the expiry cycle still counts.
        if (core_finish) begin
          out_d   = core_ct;
          sig_d   = sig_fold;
          count_d = count_inc;
          if ((target_q != '0) && (count_inc == target_q)) begin
            state_d    = StDone;
            enter_done = 1'b1;
          end else begin
            state_d = StIssue;
          end
        end else if (wd_q == WdLast) begin
          state_d = StErr;
        end else begin
          wd_d = wd_q + WdW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      target_q <= '0;
      count_q  <= '0;
      sig_q    <= '0;
      out_q    <= '0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      count_q  <= count_d;
      sig_q    <= sig_d;
      out_q    <= out_d;
      wd_q     <= wd_d;
    end
  end

  assign out_o         = out_q;
  assign signature_o   = sig_q;
  assign count_o       = count_q;
  assign busy_o        = (state_q == StIssue) || (state_q == StWait);
  assign done_o        = (state_q == StDone);
  assign timeout_err_o = (state_q == StErr);

`ifdef AES_STRESS_GOLDEN_CHECK_EN
  block_t exp_q, exp_d;
  logic   pass_q, pass_d;

  always_comb begin
    exp_d  = exp_q;
    pass_d = pass_q;
    if (go_accept) begin
      exp_d  = expected_sig_i;
      pass_d = 1'b0;
    end else if (enter_done) begin
      pass_d = (sig_fold == exp_q);
    end else if (state_d == StErr) begin
      pass_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exp_q  <= '0;
      pass_q <= 1'b0;
    end else begin
      exp_q  <= exp_d;
      pass_q <= pass_d;
    end
  end

  assign pass_o = pass_q;
`endif

endmodule

// File: tb/tb_aes_stress_harness.sv
// Directed bench for aes_stress_harness: four instances (default, short and boundary
// watchdog, 4-bit free-run) driven from one linear sequence with a ciphertext scoreboard.
module tb_aes_stress_harness;
  import aes_stress_pkg::*;

  localparam logic [127:0] C1      = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] InSeed  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KeySeed = 128'h000102030405060708090a0b0c0d0e0f;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, go_a, go_t, go_e, go_f;
  logic [31:0] iter_a, iter_t, iter_e, cnt_a, cnt_t, cnt_e;
  logic [3:0]  iter_f, cnt_f;
  logic [127:0] out_a, out_t, out_e, out_f, sig_a, sig_t, sig_e, sig_f;
  logic busy_a, busy_t, busy_e, busy_f, done_a, done_t, done_e, done_f;
  logic err_a, err_t, err_e, err_f;
`ifdef AES_STRESS_GOLDEN_CHECK_EN
  logic [127:0] exp_sig;
  logic pass_a, pass_t, pass_e, pass_f;
`endif

  aes_stress_harness u_dut (
    .clk_i(clk), .rst_i(rst), .go_i(go_a), .iterations_i(iter_a), .out_o(out_a),
    .signature_o(sig_a), .count_o(cnt_a), .busy_o(busy_a), .done_o(done_a),
    .timeout_err_o(err_a)
`ifdef AES_STRESS_GOLDEN_CHECK_EN
    , .expected_sig_i(exp_sig), .pass_o(pass_a)
`endif
  );

  aes_stress_harness #(.TIMEOUT_CYCLES(10)) u_to (
    .clk_i(clk), .rst_i(rst), .go_i(go_t), .iterations_i(iter_t), .out_o(out_t),
    .signature_o(sig_t), .count_o(cnt_t), .busy_o(busy_t), .done_o(done_t),
    .timeout_err_o(err_t)
`ifdef AES_STRESS_GOLDEN_CHECK_EN
    , .expected_sig_i(exp_sig), .pass_o(pass_t)
`endif
  );

  aes_stress_harness #(.TIMEOUT_CYCLES(11)) u_edge (
    .clk_i(clk), .rst_i(rst), .go_i(go_e), .iterations_i(iter_e), .out_o(out_e),
    .signature_o(sig_e), .count_o(cnt_e), .busy_o(busy_e), .done_o(done_e),
    .timeout_err_o(err_e)
`ifdef AES_STRESS_GOLDEN_CHECK_EN
    , .expected_sig_i(exp_sig), .pass_o(pass_e)
`endif
  );

  aes_stress_harness #(.CNT_W(4)) u_fr (
    .clk_i(clk), .rst_i(rst), .go_i(go_f), .iterations_i(iter_f), .out_o(out_f),
    .signature_o(sig_f), .count_o(cnt_f), .busy_o(busy_f), .done_o(done_f),
    .timeout_err_o(err_f)
`ifdef AES_STRESS_GOLDEN_CHECK_EN
    , .expected_sig_i(exp_sig), .pass_o(pass_f)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [127:0] sb_q[$];
  logic [127:0] m_pt, m_key, m_sig;
  logic [7:0]   sb [256];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference S-box from the log/antilog generator walk over GF(2^8).
  task automatic build_sbox();
    logic [7:0] p, q;
    p = 8'h01;
    q = 8'h01;
    for (int i = 0; i < 255; i++) begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      sb[p] = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]}
            ^ 8'h63;
    end
    sb[0] = 8'h63;
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0] s[16], t[16], k[16];
    logic [7:0] rc, a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      k[i] = key[127-8*i -: 8];
      s[i] = pt[127-8*i -: 8] ^ k[i];
    end
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      k[0] = k[0] ^ sb[k[13]] ^ rc;
      k[1] = k[1] ^ sb[k[14]];
      k[2] = k[2] ^ sb[k[15]];
      k[3] = k[3] ^ sb[k[12]];
      for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
      rc = xt(rc);
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) t[w+4*c] = sb[s[w+4*((c+w)%4)]];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ k[i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] lfsr_step(input logic [127:0] s);
    logic [127:0] n;
    n = s << 1;
    if (s[127]) n[7:0] = n[7:0] ^ 8'h87;
    return n;
  endfunction

  task automatic push_blocks(input int n);
    for (int i = 0; i < n; i++) begin
      sb_q.push_back(aes_model(m_pt, m_key));
      m_pt  = lfsr_step(m_pt);
      m_key = lfsr_step(m_key);
    end
  endtask

  // Bounded wait for u_dut's core finish; counts start pulses seen on the way.
  task automatic wait_fin(output bit ok, output int starts);
    ok = 1'b0;
    starts = 0;
    for (int i = 0; i < 40; i++) begin
      if (u_dut.core_start) starts++;
      if (u_dut.core_finish) begin
        ok = 1'b1;
        break;
      end
      tick();
      go_a = 1'b0;
    end
  endtask

  task automatic take_block(input int k, input bit last);
    bit ok;
    int starts;
    logic [127:0] exp;
    wait_fin(ok, starts);
    chk("finish_seen", 128'(ok), 128'd1);
    chk("one_start", 128'(starts), 128'd1);
    tick();
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : 'x;
    m_sig = {m_sig[126:0], m_sig[127]} ^ exp;
    chk("ciphertext", out_a, exp);
    chk("signature", sig_a, m_sig);
    chk("count", 128'(cnt_a), 128'(k));
    if (last) begin
      chk("done", 128'({done_a, busy_a}), 128'b10);
      chk("no_restart", 128'(u_dut.core_start), 128'd0);
    end else begin
      chk("gap_1cycle", 128'(u_dut.core_start), 128'd1);
    end
  endtask

  initial begin
    int n, fin;
    bit done_seen, c15;
    build_sbox();
    rst = 1'b1;
    go_a = 1'b0; go_t = 1'b0; go_e = 1'b0; go_f = 1'b0;
    iter_a = '0; iter_t = '0; iter_e = '0; iter_f = '0;
`ifdef AES_STRESS_GOLDEN_CHECK_EN
    exp_sig = C1;
`endif
    repeat (3) tick();
    chk("rst_out", out_a, '0);
    chk("rst_sig", sig_a, '0);
    chk("rst_count", 128'(cnt_a), '0);
    chk("rst_flags", 128'({busy_a, done_a, err_a}), '0);
    rst = 1'b0;
    tick();

    // Single block from the default seeds is the FIPS-197 C.1 vector.
    m_pt = InSeed; m_key = KeySeed; m_sig = '0;
    iter_a = 1; go_a = 1'b1; push_blocks(1);
    tick();
    go_a = 1'b0;
    chk("busy_issue", 128'(busy_a), 128'd1);
    take_block(1, 1'b1);
    chk("c1_out", out_a, C1);
    chk("c1_sig", sig_a, C1);
`ifdef AES_STRESS_GOLDEN_CHECK_EN
    chk("pass_match", 128'(pass_a), 128'd1);
`endif

    // Four back-to-back blocks; a go pulse during ISSUE must be ignored.
    iter_a = 4; go_a = 1'b1; push_blocks(4); m_sig = '0;
    tick();
    go_a = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (k == 2) go_a = 1'b1;
      take_block(k, k == 4);
    end

    // LFSRs continue across go, so the next single block differs from C.1.
    iter_a = 1; go_a = 1'b1; push_blocks(1); m_sig = '0;
    tick();
    go_a = 1'b0;
    take_block(1, 1'b1);
    chk("sig_changed", 128'(sig_a !== C1), 128'd1);
`ifdef AES_STRESS_GOLDEN_CHECK_EN
    chk("pass_mismatch", 128'(pass_a), 128'd0);
`endif

    // Reset in the middle of WAIT.
    iter_a = 2; go_a = 1'b1;
    tick();
    go_a = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_out", out_a, '0);
    chk("midrst_sig", sig_a, '0);
    chk("midrst_count", 128'(cnt_a), '0);
    chk("midrst_flags", 128'({busy_a, done_a, err_a}), '0);
    chk("midrst_state", 128'(u_dut.state_q), 128'(StIdle));
    repeat (20) tick();
    chk("midrst_no_count", 128'(cnt_a), '0);

    // Reset reseeds the sources.
    m_pt = InSeed; m_key = KeySeed; m_sig = '0;
    iter_a = 1; go_a = 1'b1; push_blocks(1);
    tick();
    go_a = 1'b0;
    take_block(1, 1'b1);
    chk("reseed_c1", out_a, C1);

    // Watchdog of 10 cycles expires one cycle before the core finishes.
    iter_t = 1; go_t = 1'b1;
    tick();
    go_t = 1'b0;
    chk("to_start", 128'(u_to.core_start), 128'd1);
    tick();  // core samples start on this edge
    n = 0;
    while (!err_t && n < 40) begin
      tick();
      n++;
    end
    chk("to_latency", 128'(n), 128'd10);
    chk("to_busy", 128'({busy_t, done_t}), '0);
    repeat (4) tick();
    chk("to_late_count", 128'(cnt_t), '0);
    chk("to_late_out", out_t, '0);
    go_t = 1'b1;
    tick();
    go_t = 1'b0;
    chk("to_clear", 128'({err_t, busy_t}), 128'b01);

    // Watchdog of 11 cycles: finish lands on the expiry cycle and wins.
    iter_e = 1; go_e = 1'b1;
    tick();
    go_e = 1'b0;
    n = 0;
    while (!done_e && !err_e && n < 40) begin
      tick();
      n++;
    end
    chk("edge_flags", 128'({done_e, err_e}), 128'b10);
    chk("edge_count", 128'(cnt_e), 128'd1);
    chk("edge_out", out_e, C1);

    // Free-run with a 4-bit counter wraps after 16 completions.
    iter_f = '0; go_f = 1'b1;
    tick();
    go_f = 1'b0;
    fin = 0; done_seen = 1'b0; c15 = 1'b0;
    for (int i = 0; i < 600 && fin < 16; i++) begin
      if (u_fr.core_finish) fin++;
      if (done_f) done_seen = 1'b1;
      tick();
      if (fin == 15 && !c15) begin
        c15 = 1'b1;
        chk("fr_count15", 128'(cnt_f), 128'd15);
      end
    end
    chk("fr_completions", 128'(fin), 128'd16);
    chk("fr_wrap", 128'(cnt_f), '0);
    chk("fr_no_done", 128'({done_seen, done_f, busy_f}), 128'b001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_stress_harness.md
Name: aes_stress_harness

Overview:
Parametrised self-running stress harness for the AES128_encrypt core. Two seeded LFSRs generate plaintext and key blocks, which are issued back-to-back to the core for a programmed number of iterations. Each ciphertext is folded into a 128-bit MISR signature, and a watchdog flags a core that never reports completion. The block is a top-level stress/regression wrapper and replaces the free-running harness.

Parameters:
- IN_SEED, 128'h00112233445566778899aabbccddeeff, plaintext LFSR seed (zero replaced by 1)
- KEY_SEED, 128'h000102030405060708090a0b0c0d0e0f, key LFSR seed (zero replaced by 1)
- CNT_W, 32, width of iteration target and completion counter
- TIMEOUT_CYCLES, 1024, max cycles in WAIT before error (must be >= 2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset, sampled on posedge clk; also drives the core's rst
- go  in  1  start pulse; honoured only in IDLE, DONE or ERR
- iterations  in  CNT_W  block target, sampled on go; 0 = free-run
- out  out  128  last ciphertext captured
- signature  out  128  MISR over all ciphertexts since go
- count  out  CNT_W  completed blocks since go
- busy  out  1  high in ISSUE or WAIT
- done  out  1  high in DONE
- timeout_err  out  1  high in ERR

Behaviour:
- Core contract: start is a 1-cycle pulse; the core samples in/key on the start cycle; finish is a 1-cycle pulse coincident with valid ciphertext.
- Reset: state=IDLE; out, signature, count = 0; busy, done, timeout_err = 0; LFSRs = seeds; core start = 0; watchdog = 0.
- LFSR: 128-bit Galois, polynomial x^128+x^7+x^2+x+1. Advances once per issued block only, on the ISSUE edge, so the sequence is independent of core latency.
- States:
  - IDLE: on go, latch target=iterations; clear count, signature, out; go to ISSUE.
  - ISSUE (1 cycle): start=1; in=plaintext LFSR, key=key LFSR; both LFSRs step; watchdog=0; go to WAIT.
  - WAIT: watchdog increments each cycle. On finish: out<=ct; signature<=rotl(signature,1)^ct; count<=count+1. Then go to DONE if target!=0 and count+1==target, else ISSUE. Finish-to-next-start gap is exactly 1 cycle.
  - Timeout: watchdog reaching TIMEOUT_CYCLES-1 without finish -> ERR. If finish arrives the same cycle, finish wins.
  - DONE / ERR: hold all outputs; go restarts as in IDLE (clears error). LFSRs are NOT reseeded; only rst reseeds.
- go during ISSUE/WAIT is ignored.
- Free-run (target 0): never reaches DONE; count wraps modulo 2^CNT_W.
- finish seen outside WAIT is ignored (no capture, no count).
- rst mid-operation: immediate return to reset values. The core is reset on the same edge; no completion is counted.

Optional Feature:
- Macro: AES_STRESS_GOLDEN_CHECK_EN
- Defined: adds input expected_sig [127:0] (sampled on go) and output pass [1]. On entering DONE, pass<=(signature_final==expected_sig). pass is cleared on go/rst and forced 0 in ERR.
- Undefined: neither port exists; no comparator logic.

Decomposition:
- Package aes_stress_pkg: state enum (IDLE, ISSUE, WAIT, DONE, ERR), LFSR polynomial tap constant, the 128-bit block typedef.
- Sub-module lfsr128_src (params SEED; ports clk, rst, step, out): instantiated twice.
- The AES128_encrypt core is instantiated directly.

Test Plan:
- Default seeds, iterations=1, go -> one start pulse; out = signature = 128'h69c4e0d86a7b0430d8cdb78070b4c55a (FIPS-197 C.1); count=1; done=1.
- iterations=4 -> exactly 4 start pulses, each exactly 1 cycle after the previous finish; count=4. Signature matches the model rotl/xor fold; a second go yields a different signature (LFSRs continue).
- Core stub that never asserts finish, TIMEOUT_CYCLES=16 -> timeout_err rises 16 cycles after start; busy=0; a subsequent go clears the error.
- Stub with finish on the watchdog-expiry cycle -> block counted, no ERR.
- iterations=0, CNT_W=4 -> runs past 15 completions; count wraps to 0; done never asserts.
- rst asserted in WAIT mid-block -> next cycle all outputs 0 and state IDLE. With AES_STRESS_GOLDEN_CHECK_EN, expected_sig = C.1 value and iterations=1 -> pass=1; a wrong value -> pass=0.
